// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO; frames are sent LSB-first,
// back-to-back while bytes are queued.
module uart_transmitter #(
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned CLOCK_FREQ = 25_500_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       txd
);

    localparam int unsigned BIT_PERIOD = CLOCK_FREQ / BAUD;
    localparam int unsigned CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_W    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BIT_PERIOD - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t state, state_next;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    logic [7:0]       shift_reg, shift_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic             txd_next;
    logic             busy_next;
    logic             bit_end;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    assign push = wr_en && !full;
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + COUNT_W'(1);
            2'b01:   count_next = count - COUNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Storage is not reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            full     <= (count_next == COUNT_FULL);
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine
    // ------------------------------------------------------------------
    assign bit_end = (baud_cnt == CNT_LAST);

    always_comb begin
        state_next   = state;
        txd_next     = txd;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        baud_next    = baud_cnt;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                txd_next  = 1'b1;
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    txd_next   = 1'b0;
                    state_next = START_BIT;
                end
            end

            START_BIT: begin
                if (bit_end) begin
                    baud_next    = '0;
                    txd_next     = shift_reg[0];
                    bit_idx_next = '0;
                    state_next   = DATA_BITS;
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end

            DATA_BITS: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = STOP_BIT;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        // shift_reg[1] becomes bit 0 after this shift
                        txd_next     = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end

            STOP_BIT: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        txd_next   = 1'b0;
                        state_next = START_BIT;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end

            default: begin
                txd_next   = 1'b1;
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Computed from the next state so busy rises on the same edge txd falls.
    assign busy_next = (state_next != IDLE) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            txd       <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            txd       <= txd_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            baud_cnt  <= baud_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor decodes txd frames and
// checks them against a queue of expected bytes.
module tb_uart_transmitter;

    localparam int unsigned BAUD_HZ = 115200;
    localparam int unsigned CLK_HZ  = 25_500_000;
    localparam int unsigned DEPTH   = 4;
    localparam int          BP      = CLK_HZ / BAUD_HZ;
    localparam int          MID     = BP / 2;
    localparam int          FRAME   = 10 * BP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       txd;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         frames_rx = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    logic       mon_active = 1'b0;
    logic       mon_prev = 1'b1;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;

    uart_transmitter #(
        .BAUD      (BAUD_HZ),
        .CLOCK_FREQ(CLK_HZ),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .data_in (data_in),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .overflow(overflow),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits #1 after a rising edge; returns #1 after the sampling edge.
    task automatic push(input logic [7:0] b);
        data_in = b;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        check("idle_within_budget", busy, 1'b0);
    endtask

    // Line monitor: samples every bit at its centre on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                mon_prev   = 1'b1;
            end else begin
                if (!mon_active) begin
                    if (mon_prev && !txd) begin
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    mon_cnt++;
                    if (mon_cnt == MID) begin
                        check("mon_start_bit", txd, 1'b0);
                    end else if (mon_cnt > MID && (mon_cnt - MID) % BP == 0) begin
                        if ((mon_cnt - MID) / BP <= 8) begin
                            mon_byte = {txd, mon_byte[7:1]};
                        end else begin
                            check("mon_stop_bit", txd, 1'b1);
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $error("FAIL mon_unexpected_frame: observed %0h expected no frame", mon_byte);
                            end else begin
                                check("mon_byte", mon_byte, exp_q.pop_front());
                            end
                            frames_rx++;
                            mon_active = 1'b0;
                        end
                    end
                end
                mon_prev = txd;
            end
        end
    end

    initial begin
        #(120_000 * 10);
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] v;
        int         bad;
        int         busy_low;
        int         f0;
        logic       exp_bit;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte: latency and exact bit timing
        pat = 8'h55;
        exp_q.push_back(pat);
        push(pat);
        check("lat_txd_high", txd, 1'b1);
        check("lat_empty", empty, 1'b0);
        check("lat_busy_low", busy, 1'b0);
        @(posedge clk);
        #1;
        check("lat_txd_start", txd, 1'b0);
        check("busy_rise", busy, 1'b1);
        busy_low = 0;
        for (int s = 0; s < 10; s++) begin
            exp_bit = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : pat[s-1];
            bad = 0;
            for (int c = 0; c < BP; c++) begin
                if (txd !== exp_bit) bad++;
                if (!busy) busy_low++;
                @(posedge clk);
                #1;
            end
            check($sformatf("slot%0d_hold", s), bad, 0);
        end
        check("frame_busy_held", busy_low, 0);
        check("end_busy_low", busy, 1'b0);
        check("end_txd_idle", txd, 1'b1);
        check("end_empty", empty, 1'b1);
        check("single_frames", frames_rx, 1);

        // Back-to-back
        start_q.delete();
        f0 = frames_rx;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        push(8'hA5);
        push(8'h3C);
        wait_idle(3 * FRAME);
        check("b2b_frames", frames_rx - f0, 2);
        check("b2b_starts", start_q.size(), 2);
        if (start_q.size() >= 2) check("b2b_gap", start_q[1] - start_q[0], FRAME);

        // Overflow: six pushes into a depth-4 FIFO while 0x01 is sent
        f0 = frames_rx;
        for (int k = 1; k <= 6; k++) begin
            v = 8'(k);
            if (k <= 5) exp_q.push_back(v);
            push(v);
            if (k == 5) begin
                check("ovf_full", full, 1'b1);
                check("ovf_no_pulse_yet", overflow, 1'b0);
            end
            if (k == 6) check("ovf_pulse", overflow, 1'b1);
        end
        @(posedge clk);
        #1;
        check("ovf_single_pulse", overflow, 1'b0);
        wait_idle(6 * FRAME);
        check("ovf_frames", frames_rx - f0, 5);

        // Reset during data bit 3
        f0 = frames_rx;
        exp_q.push_back(8'hF0);
        push(8'hF0);
        for (int i = 0; i < 5; i++) begin
            if (!txd) break;
            @(posedge clk);
            #1;
        end
        check("rstmid_start_seen", txd, 1'b0);
        repeat (4 * BP + BP / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid_txd", txd, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_empty", empty, 1'b1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(8'h81);
        push(8'h81);
        wait_idle(2 * FRAME);
        check("rstmid_frames", frames_rx - f0, 1);

        // Loopback patterns
        f0 = frames_rx;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        push(8'h00);
        push(8'hFF);
        push(8'h5A);
        wait_idle(4 * FRAME);
        check("loop_frames", frames_rx - f0, 3);

        // Pointer wrap-around: four bursts of three
        f0 = frames_rx;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 3; i++) begin
                v = 8'($urandom_range(0, 255));
                exp_q.push_back(v);
                push(v);
            end
            for (int i = 0; i < 3 * FRAME; i++) begin
                if (empty) break;
                @(posedge clk);
                #1;
            end
            check("wrap_drain", empty, 1'b1);
        end
        wait_idle(2 * FRAME);
        check("wrap_frames", frames_rx - f0, 12);
        check("wrap_empty", empty, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
